// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates the single off-chip SRAM between the CPU and the debug/loader port
//
// Each granted access is one fixed-timing SRAM cycle: SETUP (1 cycle), ACCESS (WAIT_CYCLES
// cycles) and DONE (1 cycle, ack to the winner). On a tie, the requester that does not own
// the previous transfer wins.
//
// Ports
//   Clk, Reset                   rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request; we/addr/wdata are sampled at grant
//   cpu_rdata, cpu_ack           CPU read data (held until the next CPU read) and completion pulse
//   dbg_*                        same set of ports for the debug/loader requester
//   CE, UB, LB, OE, WE           SRAM strobes, active-low
//   ADDR, Data_out, Data_oe      SRAM address, write data and tristate enable for the top level
//   Data_in                      value read back from the SRAM data pins
//   owner                        0 = CPU, 1 = debug; requester of the current or last transfer
//   busy                         high whenever a transfer is in progress
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_in,
    output logic              owner,
    output logic              busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              w_grant_dbg;
    logic              w_access;
    logic              w_last;

    // Debug wins when it is alone, or on a tie when the CPU owned the last transfer.
    assign w_grant_dbg = dbg_req & (~cpu_req | ~r_owner);
    assign w_access    = r_state == S_ACCESS;
    assign w_last      = w_access && r_cnt == LAST;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_owner     <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (cpu_req || dbg_req) begin
                    r_owner <= w_grant_dbg;
                    r_we    <= w_grant_dbg ? dbg_we : cpu_we;
                    r_addr  <= w_grant_dbg ? dbg_addr : cpu_addr;
                    r_wdata <= w_grant_dbg ? dbg_wdata : cpu_wdata;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_DONE;
                    if (w_last && !r_we && r_owner) r_dbg_rdata <= Data_in;
                    if (w_last && !r_we && !r_owner) r_cpu_rdata <= Data_in;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state so an asynchronous reset releases the bus at once.
    assign CE        = r_state == S_IDLE;
    assign UB        = CE;
    assign LB        = CE;
    assign OE        = ~(w_access & ~r_we);
    assign WE        = ~(w_access & r_we);
    assign Data_oe   = r_we & (r_state != S_IDLE);
    assign ADDR      = r_addr;
    assign Data_out  = r_wdata;
    assign cpu_ack   = (r_state == S_DONE) & ~r_owner;
    assign dbg_ack   = (r_state == S_DONE) & r_owner;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign owner     = r_owner;
    assign busy      = r_state != S_IDLE;
endmodule
